// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX FIFO write port among NUM_REQ byte streams.
// Optional per-requester byte counters are built when UART_ARB_STATS_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_tx_wr,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  input  logic                          i_tx_full,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_burst_cut
`ifdef UART_ARB_STATS_EN
  ,
  input  logic                          i_stats_clr,
  output logic [NUM_REQ*16-1:0]         o_byte_cnt
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam logic [7:0] LIMIT  = 8'(MAX_BURST - 1);

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [7:0]         burst_cnt_q, burst_cnt_d;
  logic               burst_cut_q, burst_cut_d;

  logic [2*NUM_REQ-1:0]  dbl;
  logic [NUM_REQ-1:0]    rot;
  logic [IW:0]           sum;
  logic [IW-1:0]         win;
  logic                  found;
  logic                  busy, valid_g, last_g, accept, at_limit;
  logic [DATA_WIDTH-1:0] sel_data;

  // Rotate valids so bit 0 is rr_ptr; the first set bit is the winner.
  always_comb begin
    dbl   = {i_req_valid, i_req_valid} >> rr_ptr_q;
    rot   = dbl[NUM_REQ-1:0];
    found = 1'b0;
    win   = rr_ptr_q;
    sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr_q} + (IW+1)'(i);
        if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
        win   = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q[i]) sel_data = sel_data | i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign busy     = (state_q == S_BUSY) && !i_rst;
  assign valid_g  = |(i_req_valid & grant_q);
  assign last_g   = |(i_req_last & grant_q);
  assign accept   = busy && valid_g && !i_tx_full;
  assign at_limit = (burst_cnt_q == LIMIT);

  assign o_req_ready = (busy && !i_tx_full) ? grant_q : '0;
  assign o_tx_wr     = accept;
  assign o_tx_data   = accept ? sel_data : '0;
  assign o_grant     = grant_q;
  assign o_burst_cut = burst_cut_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    burst_cut_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d     = S_BUSY;
          owner_d     = win;
          grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
          burst_cnt_d = '0;
        end
      end
      default: begin
        if (accept) begin
          if (last_g || at_limit) begin
            state_d     = S_IDLE;
            grant_d     = '0;
            rr_ptr_d    = (owner_q == IW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
            burst_cnt_d = '0;
            // A packet ending exactly at the limit is a normal release, not a cut.
            burst_cut_d = !last_g;
          end else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      burst_cut_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      burst_cut_q <= burst_cut_d;
    end
  end

`ifdef UART_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i_stats_clr)
        cnt_d[i] = '0;
      else if (accept && grant_q[i] && cnt_q[i] != 16'hFFFF)
        cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_byte_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues feed the DUT, a scoreboard checks every FIFO write
// for owner and byte, plus a cycle table and hand-written corner sequences.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic            tx_wr, tx_full, burst_cut;
  logic [DW-1:0]   tx_data;
`ifdef UART_ARB_STATS_EN
  logic            stats_clr;
  logic [N*16-1:0] byte_cnt;
`endif

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
    .o_req_ready(req_ready),
    .o_tx_wr(tx_wr), .o_tx_data(tx_data), .i_tx_full(tx_full),
    .o_grant(grant), .o_burst_cut(burst_cut)
`ifdef UART_ARB_STATS_EN
    , .i_stats_clr(stats_clr), .o_byte_cnt(byte_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] oh2i(input logic [N-1:0] g);
    oh2i = 3'd7;
    for (int i = 0; i < N; i++) if (g == (N'(1) << i)) oh2i = 3'(i);
  endfunction

  // Requester sources: {last, data} per byte, consumed on valid&ready.
  logic [8:0]   src_mem [N][128];
  int           src_rd [N];
  int           src_wr [N];
  logic [N-1:0] hs = '0;

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++) begin
      if (hs[k]) src_rd[k]++;
      req_valid[k]         = src_rd[k] < src_wr[k];
      req_data[k*DW +: DW] = src_mem[k][src_rd[k] % 128][7:0];
      req_last[k]          = src_mem[k][src_rd[k] % 128][8];
    end
  end

  // Scoreboard: {owner, byte} in expected grant order.
  logic [10:0] sb[$];
  logic [10:0] exp_e;
  int wr_cnt  = 0;
  int cut_cnt = 0;
  int cyc     = 0;
  int wr_cyc [1024];

  always @(negedge clk) begin
    cyc++;
    hs = req_valid & req_ready;
    if (!rst) begin
      if (tx_wr) begin
        wr_cyc[wr_cnt % 1024] = cyc;
        wr_cnt++;
        chk("wr_while_full", 32'(tx_full), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: data %0h owner %0d, nothing expected", tx_data, oh2i(grant));
        end else begin
          exp_e = sb.pop_front();
          chk("wr_owner_data", {21'd0, oh2i(grant), tx_data}, {21'd0, exp_e});
        end
      end else begin
        chk("idle_data_zero", 32'(tx_data), 32'd0);
      end
      if (burst_cut) cut_cnt++;
    end
  end

  task automatic push_exp(input int k, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) sb.push_back({3'(k), 8'(base + i)});
  endtask

  task automatic load(input int k, input int n, input logic [7:0] base, input bit push);
    for (int i = 0; i < n; i++) begin
      src_mem[k][src_wr[k] % 128] = {(i == n - 1), 8'(base + i)};
      src_wr[k]++;
    end
    if (push) push_exp(k, base, n);
  endtask

  function automatic bit pending();
    pending = 1'b0;
    for (int k = 0; k < N; k++) if (src_rd[k] < src_wr[k]) pending = 1'b1;
  endfunction

  task automatic drain(input string what);
    int b = 0;
    do begin @(posedge clk); b++; end
    while ((sb.size() != 0 || pending() || grant != 0) && b < 400);
    if (b >= 400) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: %0d bytes still expected", what, sb.size());
    end
    chk({"drain_", what}, 32'(sb.size()), 32'd0);
    #2;
  endtask

  task automatic wait_wr(input int n, input string what);
    int b = 0;
    do begin @(posedge clk); b++; end while (wr_cnt < n && b < 300);
    if (wr_cnt < n) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: writes %0d required %0d", what, wr_cnt, n);
    end
    #2;
  endtask

  task automatic clear_src();
    for (int k = 0; k < N; k++) begin
      src_rd[k] = 0;
      src_wr[k] = 0;
    end
    sb.delete();
  endtask

  typedef struct {
    logic [N-1:0]  grant;
    logic          wr;
    logic [DW-1:0] data;
    logic [N-1:0]  ready;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, c0;
    rst = 1'b1;
    tx_full = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
`ifdef UART_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    clear_src();

    // Single requester, valid already high while in reset.
    tbl[0] = '{'0, 1'b0, 8'h00, '0};
    for (int i = 1; i <= 5; i++) tbl[i] = '{4'b0001, 1'b1, 8'(8'h10 + i), 4'b0001};
    tbl[6] = '{'0, 1'b0, 8'h00, '0};
    tbl[7] = '{'0, 1'b0, 8'h00, '0};
    load(0, 5, 8'h11, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_wr", 32'(tx_wr), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_burst_cut", 32'(burst_cut), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
      chk($sformatf("tbl%0d_wr", i), 32'(tx_wr), 32'(tbl[i].wr));
      chk($sformatf("tbl%0d_data", i), 32'(tx_data), 32'(tbl[i].data));
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].ready));
      @(posedge clk); #2;
    end
    chk("single_drained", 32'(sb.size()), 32'd0);
`ifdef UART_ARB_STATS_EN
    chk("stats_req0", 32'(byte_cnt[15:0]), 32'd5);
`endif

    // Round robin from rr_ptr=0: four 2-byte packets, then 0 and 2 again.
    rst = 1'b1;
    clear_src();
    repeat (2) @(posedge clk); #2;
    rst = 1'b0;
    w0 = wr_cnt;
    for (int k = 0; k < N; k++) load(k, 2, 8'(8'h20 + 16 * k), 1'b1);
    drain("rr");
    chk("rr_span_cycles", 32'(wr_cyc[(w0 + 7) % 1024] - wr_cyc[w0 % 1024] + 1), 32'd11);
    load(0, 2, 8'h80, 1'b1);
    load(2, 2, 8'h90, 1'b1);
    drain("rr_wrap");

    // Burst limit: rr_ptr=3, so req1 wins, is cut after 16, req2 goes, then req1 finishes.
    c0 = cut_cnt;
    load(1, 20, 8'h40, 1'b0);
    load(2, 3, 8'h70, 1'b0);
    push_exp(1, 8'h40, 16);
    push_exp(2, 8'h70, 3);
    push_exp(1, 8'h50, 4);
    drain("burst");
    chk("burst_cut_count", 32'(cut_cnt - c0), 32'd1);

    // Backpressure mid-packet: rr_ptr=2, req3 then req0, 8 bytes each.
    load(3, 8, 8'hC0, 1'b1);
    load(0, 8, 8'hD0, 1'b1);
    wait_wr(wr_cnt + 3, "bp_start");
    tx_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_wr", 32'(tx_wr), 32'd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #2;
    tx_full = 1'b0;
    drain("bp");

    // Last byte coincides with the limit: no cut.
    c0 = cut_cnt;
    load(1, 16, 8'hE0, 1'b1);
    drain("coincide");
    chk("cut_on_last", 32'(cut_cnt - c0), 32'd0);

    // Async reset during byte 3 of 6 from req2 (rr_ptr=2 beforehand).
    load(2, 6, 8'h30, 1'b1);
    wait_wr(wr_cnt + 2, "rst_start");
    chk("byte3_presented", 32'(tx_wr), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_wr", 32'(tx_wr), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
`ifdef UART_ARB_STATS_EN
    chk("midrst_stats", 32'(byte_cnt == '0), 32'd1);
`endif
    clear_src();
    @(posedge clk); #2;
    rst = 1'b0;
    load(0, 3, 8'hA0, 1'b1);
    load(3, 2, 8'hB0, 1'b1);
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
